array_memory_engine: RTL

//  Clocked, multi-cycle successor to the combinational array Memory used by the fpga test harness.

---
 rtl/array_memory_engine.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/array_memory_engine.sv
// rtl/array_memory_engine.sv - multi-cycle fixed-block array memory with push/pop/scan actions
// Optional MEMORY_BOUNDS_CHECK_EN: report read/push/pop bounds errors instead of tolerating them.
module array_memory_engine #(
    parameter int ADDRESS_BITS = 8,
    parameter int INDEX_BITS   = 3,
    parameter int DATA_BITS    = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [7:0]              action,
    input  logic [ADDRESS_BITS-1:0] array,
    input  logic [INDEX_BITS-1:0]   index,
    input  logic [DATA_BITS-1:0]    in,
    output logic                    busy,
    output logic                    done,
    output logic [DATA_BITS-1:0]    out,
    output logic [31:0]             error
);
    localparam int ARRAYS       = 1 << ADDRESS_BITS;
    localparam int ARRAY_LENGTH = 1 << INDEX_BITS;
    localparam logic [INDEX_BITS:0] FULL_SIZE = {1'b1, {INDEX_BITS{1'b0}}};
    localparam logic [INDEX_BITS:0] ONE       = 1;

    localparam logic [7:0] ACT_CLEAR   = 8'd1;
    localparam logic [7:0] ACT_WRITE   = 8'd2;
    localparam logic [7:0] ACT_READ    = 8'd3;
    localparam logic [7:0] ACT_SIZE    = 8'd4;
    localparam logic [7:0] ACT_PUSH    = 8'd5;
    localparam logic [7:0] ACT_POP     = 8'd6;
    localparam logic [7:0] ACT_LESS    = 8'd7;
    localparam logic [7:0] ACT_EQUAL   = 8'd8;
    localparam logic [7:0] ACT_GREATER = 8'd9;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SCAN} state_t;
    state_t state;

    // Element storage has no reset so it maps onto RAM; only sizes are cleared.
    logic [DATA_BITS-1:0]    mem [ARRAYS*ARRAY_LENGTH];
    logic [INDEX_BITS:0]     sizes [ARRAYS];

    logic [7:0]              cap_action;
    logic [ADDRESS_BITS-1:0] cap_array;
    logic [INDEX_BITS-1:0]   cap_index;
    logic [DATA_BITS-1:0]    cap_in;
    logic [INDEX_BITS:0]     cap_size;
    logic [INDEX_BITS:0]     k;
    logic [INDEX_BITS:0]     cnt;

    logic [INDEX_BITS:0]     size_m1;
    logic [INDEX_BITS:0]     index_plus1;
    logic [INDEX_BITS-1:0]   rd_index;
    logic [DATA_BITS-1:0]    rd_data;
    logic                    we;
    logic [INDEX_BITS-1:0]   wr_index;

    assign size_m1     = cap_size - ONE;
    assign index_plus1 = {1'b0, cap_index} + ONE;

    // An empty pop reads element 0 rather than wrapping to the top slot.
    always_comb begin
        rd_index = cap_index;
        if (state == S_SCAN)
            rd_index = k[INDEX_BITS-1:0];
        else if (cap_action == ACT_POP)
            rd_index = (cap_size == '0) ? '0 : size_m1[INDEX_BITS-1:0];
    end

    assign rd_data  = mem[{cap_array, rd_index}];
    assign we       = (state == S_EXEC) &&
                      ((cap_action == ACT_WRITE) ||
                       (cap_action == ACT_PUSH && cap_size != FULL_SIZE));
    assign wr_index = (cap_action == ACT_PUSH) ? cap_size[INDEX_BITS-1:0] : cap_index;

    always_ff @(posedge clock) begin
        if (we)
            mem[{cap_array, wr_index}] <= cap_in;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            out        <= '0;
            error      <= '0;
            cap_action <= '0;
            cap_array  <= '0;
            cap_index  <= '0;
            cap_in     <= '0;
            cap_size   <= '0;
            k          <= '0;
            cnt        <= '0;
            for (int a = 0; a < ARRAYS; a++)
                sizes[a] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cap_action <= action;
                        cap_array  <= array;
                        cap_index  <= index;
                        cap_in     <= in;
                        cap_size   <= sizes[array];
                        k          <= '0;
                        cnt        <= '0;
                        busy       <= 1'b1;
                        state      <= (action >= ACT_LESS && action <= ACT_GREATER) ? S_SCAN : S_EXEC;
                    end
                end
                S_EXEC: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    error <= '0;
                    case (cap_action)
                        ACT_CLEAR: sizes[cap_array] <= '0;
                        ACT_WRITE: begin
                            if (index_plus1 > cap_size)
                                sizes[cap_array] <= index_plus1;
                        end
                        ACT_READ: begin
`ifdef MEMORY_BOUNDS_CHECK_EN
                            if ({1'b0, cap_index} >= cap_size)
                                error <= 32'd1;
                            else
                                out <= rd_data;
`else
                            out <= rd_data;
`endif
                        end
                        ACT_SIZE: out <= DATA_BITS'(cap_size);
                        ACT_PUSH: begin
                            if (cap_size == FULL_SIZE) begin
`ifdef MEMORY_BOUNDS_CHECK_EN
                                error <= 32'd2;
`endif
                            end else begin
                                sizes[cap_array] <= cap_size + ONE;
                            end
                        end
                        ACT_POP: begin
                            if (cap_size == '0) begin
`ifdef MEMORY_BOUNDS_CHECK_EN
                                error <= 32'd3;
`else
                                out <= rd_data;
`endif
                            end else begin
                                sizes[cap_array] <= size_m1;
                                out              <= rd_data;
                            end
                        end
                        default: error <= 32'd4;
                    endcase
                end
                S_SCAN: begin
                    if (k == cap_size) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        error <= '0;
                        out   <= DATA_BITS'(cnt);
                    end else begin
                        k <= k + ONE;
                        case (cap_action)
                            ACT_LESS:  if (rd_data < cap_in)  cnt <= cnt + ONE;
                            ACT_EQUAL: if (rd_data == cap_in) cnt <= cnt + ONE;
                            default:   if (rd_data > cap_in)  cnt <= cnt + ONE;
                        endcase
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
